// File: rtl/hazard_unit_rv32i.sv
// Hazard controller for the 5-stage RV32I pipeline: execute-stage operand
// forwarding, load-use / data-memory-wait / taken-branch / fetch-miss
// handling, and per-stage enable (hold) and flush (bubble) controls.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | after reset: every stage held and flushed, forwarding off
// RUN   | normal operation, absorbing until the next reset
module hazard_unit_rv32i #(
    parameter int REG_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] r1_D,
    input  logic [REG_ADDR_W-1:0] r2_D,
    input  logic [REG_ADDR_W-1:0] r1_E,
    input  logic [REG_ADDR_W-1:0] r2_E,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic                  reg_write_M,
    input  logic                  reg_write_W,
    input  logic                  mem_to_reg_E,
    input  logic                  PC_source_E,
    input  logic                  mem_transaction,
    input  logic                  data_ready,
    input  logic                  instruction_ready,
    output logic [1:0]            forward_operand_0_E,
    output logic [1:0]            forward_operand_1_E,
    output logic                  enable_fetch,
    output logic                  enable_decode,
    output logic                  enable_execute,
    output logic                  enable_memory,
    output logic                  enable_writeback,
    output logic                  flush_decode,
    output logic                  flush_execute,
    output logic                  flush_memory
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       run;
    logic       lw_stall;
    logic       dmem_stall;
    logic       m_hit_0;
    logic       m_hit_1;
    logic       w_hit_0;
    logic       w_hit_1;

    // Sequencer next state: leave INIT on the first edge out of reset, then stay in RUN.
    always_comb begin
        state_d = ST_RUN;
    end

    // Sequencer state register with asynchronous clear to INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // rst_n is folded in directly so a mid-run reset forces the safe outputs at once.
    assign run = rst_n && (state_q == ST_RUN);

    assign m_hit_0 = reg_write_M && (rd_M != '0) && (rd_M == r1_E);
    assign m_hit_1 = reg_write_M && (rd_M != '0) && (rd_M == r2_E);
    assign w_hit_0 = reg_write_W && (rd_W != '0) && (rd_W == r1_E);
    assign w_hit_1 = reg_write_W && (rd_W != '0) && (rd_W == r2_E);

    assign lw_stall   = mem_to_reg_E && (rd_E != '0) && ((rd_E == r1_D) || (rd_E == r2_D));
    assign dmem_stall = mem_transaction && !data_ready;

    // Operand forwarding; the memory stage holds the younger value so it wins over writeback.
    always_comb begin
        forward_operand_0_E = FWD_RF;
        forward_operand_1_E = FWD_RF;
        if (run) begin
            if (m_hit_0) begin
                forward_operand_0_E = FWD_MEM;
            end else if (w_hit_0) begin
                forward_operand_0_E = FWD_WB;
            end
            if (m_hit_1) begin
                forward_operand_1_E = FWD_MEM;
            end else if (w_hit_1) begin
                forward_operand_1_E = FWD_WB;
            end
        end
    end

    // Stage enables and flushes: data wait freezes everything, then taken branch, then load-use / fetch miss.
    always_comb begin
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_memory    = 1'b0;
        enable_writeback = 1'b0;
        flush_decode     = 1'b1;
        flush_execute    = 1'b1;
        flush_memory     = 1'b1;
        if (run) begin
            if (dmem_stall) begin
                flush_decode  = 1'b0;
                flush_execute = 1'b0;
                flush_memory  = 1'b0;
            end else if (PC_source_E) begin
                // Fetch loads the branch target even if the current fetch missed.
                enable_fetch     = 1'b1;
                enable_decode    = 1'b1;
                enable_execute   = 1'b1;
                enable_memory    = 1'b1;
                enable_writeback = 1'b1;
                flush_decode     = 1'b1;
                flush_execute    = 1'b1;
                flush_memory     = 1'b0;
            end else begin
                enable_fetch     = !lw_stall && instruction_ready;
                enable_decode    = !lw_stall;
                enable_execute   = 1'b1;
                enable_memory    = 1'b1;
                enable_writeback = 1'b1;
                // A held decode register must keep its instruction, so no miss bubble during load-use.
                flush_decode     = !instruction_ready && !lw_stall;
                flush_execute    = lw_stall;
                flush_memory     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_rv32i.sv
// Bench for hazard_unit_rv32i: a rule-level reference model checked against
// the DUT every cycle, plus hand-computed literal vectors that pin the model.
module tb_hazard_unit_rv32i;

    logic       clk;
    logic       rst_n;
    logic [5:0] r1_D, r2_D, r1_E, r2_E, rd_E, rd_M, rd_W;
    logic       reg_write_M, reg_write_W, mem_to_reg_E, PC_source_E;
    logic       mem_transaction, data_ready, instruction_ready;
    logic [1:0] forward_operand_0_E, forward_operand_1_E;
    logic       enable_fetch, enable_decode, enable_execute, enable_memory, enable_writeback;
    logic       flush_decode, flush_execute, flush_memory;

    int errors = 0;
    int checks = 0;
    bit m_run = 1'b0;

    hazard_unit_rv32i #(.REG_ADDR_W(6)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r1_D                (r1_D),
        .r2_D                (r2_D),
        .r1_E                (r1_E),
        .r2_E                (r2_E),
        .rd_E                (rd_E),
        .rd_M                (rd_M),
        .rd_W                (rd_W),
        .reg_write_M         (reg_write_M),
        .reg_write_W         (reg_write_W),
        .mem_to_reg_E        (mem_to_reg_E),
        .PC_source_E         (PC_source_E),
        .mem_transaction     (mem_transaction),
        .data_ready          (data_ready),
        .instruction_ready   (instruction_ready),
        .forward_operand_0_E (forward_operand_0_E),
        .forward_operand_1_E (forward_operand_1_E),
        .enable_fetch        (enable_fetch),
        .enable_decode       (enable_decode),
        .enable_execute      (enable_execute),
        .enable_memory       (enable_memory),
        .enable_writeback    (enable_writeback),
        .flush_decode        (flush_decode),
        .flush_execute       (flush_execute),
        .flush_memory        (flush_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {fwd0, fwd1, en F D E M W, flush D E M}
    function automatic logic [11:0] dut_vec();
        return {forward_operand_0_E, forward_operand_1_E,
                enable_fetch, enable_decode, enable_execute, enable_memory, enable_writeback,
                flush_decode, flush_execute, flush_memory};
    endfunction

    // Sequencer model: any reset clears it, any clock edge out of reset means running.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_run = 1'b0;
        else        m_run = 1'b1;
    end

    function automatic logic [1:0] fwd_sel(input logic [5:0] r);
        if (reg_write_M && rd_M != 6'd0 && rd_M == r) return 2'b10;
        if (reg_write_W && rd_W != 6'd0 && rd_W == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model();
        bit lw, dm;
        logic [4:0] en;
        logic [2:0] fl;
        if (!m_run || !rst_n) return 12'b00_00_00000_111;
        lw = mem_to_reg_E && rd_E != 6'd0 && (rd_E == r1_D || rd_E == r2_D);
        dm = mem_transaction && !data_ready;
        if (dm) begin
            en = 5'b00000; fl = 3'b000;
        end else if (PC_source_E) begin
            en = 5'b11111; fl = 3'b110;
        end else begin
            en = {!lw && instruction_ready, !lw, 3'b111};
            fl = {!instruction_ready && !lw, lw, 1'b0};
        end
        return {fwd_sel(r1_E), fwd_sel(r2_E), en, fl};
    endfunction

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        checks++;
        if (dut_vec() !== model()) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_vec(), model());
        end
    end

    task automatic lit(input string name, input logic [11:0] want);
        checks++;
        if (dut_vec() !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, dut_vec(), want);
        end
    endtask

    task automatic idle_inputs();
        r1_D = 6'd0; r2_D = 6'd1; r1_E = 6'd2; r2_E = 6'd3;
        rd_E = 6'd4; rd_M = 6'd5; rd_W = 6'd6;
        reg_write_M = 0; reg_write_W = 0; mem_to_reg_E = 0; PC_source_E = 0;
        mem_transaction = 0; data_ready = 0; instruction_ready = 0;
    endtask

    // Wait for the next falling edge, then move inputs just after it.
    task automatic next_slot();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1 lit("reset_asserted", 12'b00_00_00000_111);
        #6 rst_n = 1'b1;                       // released after the edge at t=5
        @(negedge clk);                        // t=10, still INIT
        lit("init_before_edge", 12'b00_00_00000_111);
        next_slot();                           // edge at t=15 moved to RUN
        lit("idle_run", 12'b00_00_01111_100);

        r1_E = 6'd5; rd_M = 6'd5; reg_write_M = 1;
        next_slot(); lit("fwd0_mem", 12'b10_00_01111_100);
        r2_E = 6'd6; rd_W = 6'd6; reg_write_W = 1;
        next_slot(); lit("fwd1_wb", 12'b10_01_01111_100);
        rd_M = 6'd7; rd_W = 6'd7; r1_E = 6'd7;
        next_slot(); lit("fwd_mem_priority", 12'b10_00_01111_100);
        rd_M = 6'd0; r1_E = 6'd0;
        next_slot(); lit("fwd_x0_ignored", 12'b00_00_01111_100);

        idle_inputs();
        mem_to_reg_E = 1; rd_E = 6'd1; r2_D = 6'd1; instruction_ready = 1;
        next_slot(); lit("load_use", 12'b00_00_00111_010);
        rd_E = 6'd0;
        next_slot(); lit("load_use_x0", 12'b00_00_11111_000);

        rd_E = 6'd1; PC_source_E = 1;
        next_slot(); lit("branch_over_lw", 12'b00_00_11111_110);
        instruction_ready = 0;
        next_slot(); lit("branch_fetch_miss", 12'b00_00_11111_110);

        mem_transaction = 1; data_ready = 0;
        r1_E = 6'd5; rd_M = 6'd5; reg_write_M = 1;
        next_slot(); lit("dmem_freeze", 12'b10_00_00000_000);
        data_ready = 1;
        next_slot(); lit("dmem_done_branch", 12'b10_00_11111_110);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 12'b00_00_00000_111);
        #1 rst_n = 1'b1;
        @(negedge clk);
        lit("init_after_release", 12'b00_00_00000_111);
        next_slot();
        lit("run_after_reset", 12'b10_00_11111_110);

        // Varied vectors over a small register range so matches are frequent.
        for (int i = 0; i < 60; i++) begin
            r1_D = 6'($urandom_range(0, 3)); r2_D = 6'($urandom_range(0, 3));
            r1_E = 6'($urandom_range(0, 3)); r2_E = 6'($urandom_range(0, 3));
            rd_E = 6'($urandom_range(0, 3)); rd_M = 6'($urandom_range(0, 3));
            rd_W = 6'($urandom_range(0, 3));
            if (i == 30) rd_M = 6'd35;         // upper bits must take part in equality
            reg_write_M = 1'($urandom); reg_write_W = 1'($urandom);
            mem_to_reg_E = 1'($urandom); PC_source_E = 1'($urandom);
            mem_transaction = 1'($urandom); data_ready = 1'($urandom);
            instruction_ready = 1'($urandom);
            next_slot();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit_rv32i.md
Name: hazard_unit_rv32i

Overview:
Central hazard controller for the 5-stage RV32I pipeline (fetch, decode, execute, memory, writeback).
- Selects forwarding paths for both execute-stage operands.
- Detects load-use hazards, taken branches/jumps, instruction-fetch misses and data-memory waits.
- Drives per-stage enable (hold) and flush (bubble) controls.
- Forwarding and stall/flush logic is combinational. A one-state-bit sequencer guarantees a clean pipeline flush after reset.

Parameters:
REG_ADDR_W, 6, register-index width; index 0 is the hard-wired zero register.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
r1_D  in  6  source register 1 of instruction in decode
r2_D  in  6  source register 2 of instruction in decode
r1_E  in  6  source register 1 of instruction in execute
r2_E  in  6  source register 2 of instruction in execute
rd_E  in  6  destination of instruction in execute
rd_M  in  6  destination of instruction in memory
rd_W  in  6  destination of instruction in writeback
reg_write_M  in  1  memory-stage instruction writes rd_M
reg_write_W  in  1  writeback-stage instruction writes rd_W
mem_to_reg_E  in  1  execute-stage instruction is a load
PC_source_E  in  1  taken branch/jump resolved in execute
mem_transaction  in  1  memory stage has an outstanding data access
data_ready  in  1  data memory completes the access this cycle
instruction_ready  in  1  instruction memory output valid this cycle
forward_operand_0_E  out  2  operand-0 mux: 00 regfile, 01 writeback result, 10 memory-stage ALU result
forward_operand_1_E  out  2  operand-1 mux, same encoding
enable_fetch  out  1  PC/fetch register load enable
enable_decode  out  1  F/D register load enable
enable_execute  out  1  D/E register load enable
enable_memory  out  1  E/M register load enable
enable_writeback  out  1  M/W register load enable
flush_decode  out  1  F/D register loads bubble
flush_execute  out  1  D/E register loads bubble
flush_memory  out  1  E/M register loads bubble

Behaviour:
Sequencer:
- States INIT and RUN.
- rst_n low forces INIT asynchronously.
- The first rising clk edge with rst_n high moves INIT to RUN; RUN is absorbing.
- While rst_n is low or the state is INIT:
  - all enable_* = 0
  - flush_decode = flush_execute = flush_memory = 1
  - forward_* = 00
- Reset mid-operation returns to these values immediately, without waiting for a clock edge.

Forwarding (RUN, applied independently to each operand; r = r1_E for operand 0, r2_E for operand 1):
- 10 if reg_write_M, rd_M != 0 and rd_M == r.
- Else 01 if reg_write_W, rd_W != 0 and rd_W == r.
- Else 00.
- Memory stage has priority over writeback when both match.
- Forwarding stays active during all stalls.

Hazard detection (RUN):
- lw_stall = mem_to_reg_E & rd_E != 0 & (rd_E == r1_D | rd_E == r2_D).
- dmem_stall = mem_transaction & ~data_ready.

Stage control priority (RUN), highest first:
1. dmem_stall: all five enables = 0; all flushes = 0 (full freeze). Overrides branch, load-use and fetch miss.
2. PC_source_E: all enables = 1, including fetch even when instruction_ready = 0 (PC takes the target). flush_decode = 1, flush_execute = 1, flush_memory = 0. lw_stall is ignored.
3. Otherwise:
   - enable_fetch = ~lw_stall & instruction_ready
   - enable_decode = ~lw_stall
   - enable_execute = enable_memory = enable_writeback = 1
   - flush_decode = ~instruction_ready & ~lw_stall
   - flush_execute = lw_stall
   - flush_memory = 0

Additional rules:
- Flush dominates enable inside the pipeline registers.
- Outputs are purely combinational from inputs and state; no added latency.
- No latches.
- Comparisons are full 6-bit equality.

Test Plan:
- Reset then idle: rst_n=0 -> enables 0, flushes 111, forwards 00. Release and one clk edge, with r1_D=0, r2_D=1, r1_E=2, r2_E=3, rd_E=4, rd_M=5, rd_W=6, all controls 0, instruction_ready=0 -> forwards 00, enable_fetch=0, enable_decode/execute/memory/writeback=1, flush_decode=1, flush_execute=0, flush_memory=0.
- Forwarding: r1_E=5, rd_M=5, reg_write_M=1 -> fwd0=10. Then r2_E=6, rd_W=6, reg_write_W=1 -> fwd1=01. Then rd_M=rd_W=r1_E=7, both writes set -> fwd0=10. Then rd_M=r1_E=0 -> fwd0=00.
- Load-use: mem_to_reg_E=1, rd_E=1=r2_D, instruction_ready=1 -> enable_fetch=0, enable_decode=0, flush_execute=1, flush_decode=0. With rd_E=0 -> no stall.
- Taken branch: PC_source_E=1 with a load-use condition present -> enable_fetch=1, enable_decode=1, flush_decode=1, flush_execute=1, flush_memory=0.
- Data wait: mem_transaction=1, data_ready=0, PC_source_E=1 -> all enables 0, all flushes 0. Raise data_ready=1 -> branch response resumes.
- Async reset mid-run: drop rst_n between clock edges -> outputs switch to reset values immediately; one edge after release -> RUN.
